// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   DefXlen / DefNreg : default data width and register count
//   clog2()           : address width for a given register count
package regfile_mp_pkg;

    localparam int unsigned DefXlen = 32;
    localparam int unsigned DefNreg = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_rport.sv
// One registered read port of regfile_mp.
//   clk, rst_n          : clock, async active-low reset
//   re, ra              : read enable and address for this port
//   rf, busy            : flattened register array and live scoreboard
//   wr_ok, wa, wr_merged: qualified same-edge write and its byte-merged data
//   rd, rd_busy         : registered read data and scoreboard status
module regfile_rport
    import regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN   = DefXlen,
    parameter int unsigned NREG   = DefNreg,
    parameter int unsigned AW     = clog2(DefNreg),
    parameter bit          BYPASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   re,
    input  logic [AW-1:0]          ra,
    input  logic [NREG*XLEN-1:0]   rf,
    input  logic [NREG-1:0]        busy,
    input  logic                   wr_ok,
    input  logic [AW-1:0]          wa,
    input  logic [XLEN-1:0]        wr_merged,
    output logic [XLEN-1:0]        rd,
    output logic                   rd_busy
);

    logic            addr_ok;
    logic            hit;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] rd_d, rd_q;
    logic            rb_d, rb_q;

    always_comb begin
        addr_ok = (ra != '0) && (32'(ra) < NREG);
        // Clamp so the array select never leaves its range; result is masked anyway.
        idx     = addr_ok ? ra : '0;
        // wr_ok already excludes r0 and out-of-range addresses.
        hit     = BYPASS && wr_ok && (wa == ra);
        rd_d    = rd_q;
        rb_d    = rb_q;
        if (re) begin
            if (hit) begin
                // Forward the new value; the write clears the busy bit this edge.
                rd_d = wr_merged;
                rb_d = 1'b0;
            end else if (addr_ok) begin
                rd_d = rf[32'(idx)*XLEN +: XLEN];
                rb_d = busy[idx];
            end else begin
                rd_d = '0;
                rb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            rb_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            rb_q <= rb_d;
        end
    end

    assign rd      = rd_q;
    assign rd_busy = rb_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write and a busy scoreboard.
//   clk, rst_n   : clock, async active-low reset
//   re, ra       : per-port read enables / addresses (port i at ra[i*AW +: AW])
//   rd, rd_busy  : per-port registered read data / scoreboard status
//   we, wa, wd   : write enable, address, data;  wbe : byte enables
//   bs, ba       : scoreboard set request and address
//   busy         : live scoreboard vector (bit 0 always 0)
(* keep_hierarchy = "yes" *)
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN   = DefXlen,
    parameter int unsigned NREG   = DefNreg,
    parameter int unsigned NRP    = 2,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP-1:0]      re,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*XLEN-1:0] rd,
    output logic [NRP-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [XLEN/8-1:0]   wbe,
    input  logic                bs,
    input  logic [AW-1:0]       ba,
    output logic [NREG-1:0]     busy
);

    localparam int unsigned NB = XLEN / 8;

    logic [NREG*XLEN-1:0] rf_d, rf_q;
    logic [NREG-1:0]      busy_d, busy_q;
    logic                 wr_ok, set_ok;
    logic [AW-1:0]        wa_idx, ba_idx;
    logic [XLEN-1:0]      wr_old, wr_merged;

    always_comb begin
        wr_ok     = we && (wa != '0) && (32'(wa) < NREG);
        set_ok    = bs && (ba != '0) && (32'(ba) < NREG);
        wa_idx    = wr_ok ? wa : '0;
        ba_idx    = set_ok ? ba : '0;
        wr_old    = rf_q[32'(wa_idx)*XLEN +: XLEN];
        wr_merged = wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                wr_merged[b*8 +: 8] = wd[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (wr_ok) begin
            rf_d[32'(wa_idx)*XLEN +: XLEN] = wr_merged;
            busy_d[wa_idx]                 = 1'b0;
        end
        // Applied after the clear so a same-edge set wins.
        if (set_ok) begin
            busy_d[ba_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q   <= '0;
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar p = 0; p < NRP; p++) begin : g_rport
        regfile_rport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rport (
            .clk       (clk),
            .rst_n     (rst_n),
            .re        (re[p]),
            .ra        (ra[p*AW +: AW]),
            .rf        (rf_q),
            .busy      (busy_q),
            .wr_ok     (wr_ok),
            .wa        (wa),
            .wr_merged (wr_merged),
            .rd        (rd[p*XLEN +: XLEN]),
            .rd_busy   (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: DUT 0 is NREG=32 with forwarding, DUT 1 is NREG=20
// without forwarding (exposes out-of-range addresses). Both share stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  re;
    logic [9:0]  ra;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic        bs;
    logic [4:0]  ba;

    logic [63:0] rd0, rd1;
    logic [1:0]  rdb0, rdb1;
    logic [31:0] busy0;
    logic [19:0] busy1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index k selects the DUT.
    logic [31:0] mreg [2][32];
    logic [31:0] mbusy [2];
    logic [31:0] mrd [2][2];
    logic [1:0]  mrdb [2];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rd(rd0), .rd_busy(rdb0),
        .we(we), .wa(wa), .wd(wd), .wbe(wbe), .bs(bs), .ba(ba), .busy(busy0)
    );

    regfile_mp #(.XLEN(32), .NREG(20), .NRP(2), .BYPASS(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rd(rd1), .rd_busy(rdb1),
        .we(we), .wa(wa), .wd(wd), .wbe(wbe), .bs(bs), .ba(ba), .busy(busy1)
    );

    function automatic int nreg_of(int k);
        return (k == 0) ? 32 : 20;
    endfunction

    function automatic bit valid(int k, logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nreg_of(k));
    endfunction

    function automatic logic [31:0] act_rd(int k, int i);
        return (k == 0) ? rd0[i*32 +: 32] : rd1[i*32 +: 32];
    endfunction

    function automatic logic act_rdb(int k, int i);
        return (k == 0) ? rdb0[i] : rdb1[i];
    endfunction

    function automatic logic [31:0] act_busy(int k);
        return (k == 0) ? busy0 : {12'd0, busy1};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mreg[k][r] = '0;
            mbusy[k] = '0;
            mrdb[k]  = '0;
            mrd[k][0] = '0;
            mrd[k][1] = '0;
        end
    endtask

    // Applies one rising edge of the architectural rules to the model.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit          wr;
            logic [31:0] merged;
            logic [4:0]  a;
            wr = we && valid(k, wa);
            merged = wr ? mreg[k][wa] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
            end
            for (int i = 0; i < 2; i++) begin
                a = ra[i*5 +: 5];
                if (re[i]) begin
                    if (!valid(k, a)) begin
                        mrd[k][i] = '0;
                        mrdb[k][i] = 1'b0;
                    end else if (k == 0 && wr && wa == a) begin
                        mrd[k][i] = merged;
                        mrdb[k][i] = 1'b0;
                    end else begin
                        mrd[k][i] = mreg[k][a];
                        mrdb[k][i] = mbusy[k][a];
                    end
                end
            end
            if (wr) begin
                mreg[k][wa] = merged;
                mbusy[k][wa] = 1'b0;
            end
            if (bs && valid(k, ba)) mbusy[k][ba] = 1'b1;
        end
    endtask

    task automatic idle();
        re = '0; ra = '0; we = 1'b0; wa = '0; wd = '0; wbe = '0; bs = 1'b0; ba = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #12;
        for (int k = 0; k < 2; k++) begin
            if (act_rd(k, 0) !== 32'd0 || act_rd(k, 1) !== 32'd0 || act_busy(k) !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: rd=%h/%h busy=%h want 0", k,
                         act_rd(k, 0), act_rd(k, 1), act_busy(k));
            end
            n_cmp++;
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        re = 2'b01; ra = {5'd0, 5'd5};
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_rd(k, 0) !== 32'd0 || act_rdb(k, 0) !== 1'b0) begin
                n_bad++;
                $display("FAIL read_r5_after_reset dut%0d: rd=%h busy=%b want 0/0", k,
                         act_rd(k, 0), act_rdb(k, 0));
            end
            n_cmp++;
        end
    endtask

    task automatic test_byte_write();
        idle(); we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; wbe = 4'hF;
        tick();
        wd = 32'h000000AA; wbe = 4'h1;
        tick();
        idle(); re = 2'b01; ra = {5'd0, 5'd5};
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_rd(k, 0) !== 32'hDEADBEAA) begin
                n_bad++;
                $display("FAIL byte_merge dut%0d: got %h want deadbeaa", k, act_rd(k, 0));
            end
            n_cmp++;
        end
    endtask

    task automatic test_same_edge();
        idle(); we = 1'b1; wa = 5'd7; wd = 32'h12345678; wbe = 4'hF;
        re = 2'b11; ra = {5'd7, 5'd7};
        tick();
        for (int i = 0; i < 2; i++) begin
            if (act_rd(0, i) !== 32'h12345678) begin
                n_bad++;
                $display("FAIL bypass_on port%0d: got %h want 12345678", i, act_rd(0, i));
            end
            n_cmp++;
            if (act_rd(1, i) !== 32'h0) begin
                n_bad++;
                $display("FAIL bypass_off port%0d: got %h want 00000000", i, act_rd(1, i));
            end
            n_cmp++;
        end
    endtask

    task automatic test_r0();
        idle(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wbe = 4'hF;
        tick();
        idle(); re = 2'b01; ra = '0;
        tick();
        idle(); bs = 1'b1; ba = 5'd0;
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_rd(k, 0) !== 32'd0 || act_busy(k) !== mbusy[k] || act_busy(k) !== 32'd0) begin
                n_bad++;
                $display("FAIL r0_zero dut%0d: rd=%h busy=%h want 0/0", k,
                         act_rd(k, 0), act_busy(k));
            end
            n_cmp++;
        end
    endtask

    task automatic test_scoreboard();
        idle(); bs = 1'b1; ba = 5'd3;
        tick();
        idle(); re = 2'b01; ra = {5'd0, 5'd3};
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_rdb(k, 0) !== 1'b1) begin
                n_bad++;
                $display("FAIL sb_read_busy dut%0d: got %b want 1", k, act_rdb(k, 0));
            end
            n_cmp++;
        end
        idle(); bs = 1'b1; ba = 5'd3; we = 1'b1; wa = 5'd3; wbe = 4'h0;
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_busy(k)[3] !== 1'b1) begin
                n_bad++;
                $display("FAIL sb_set_wins dut%0d: busy3=%b want 1", k, act_busy(k)[3]);
            end
            n_cmp++;
        end
        idle(); we = 1'b1; wa = 5'd3; wbe = 4'h0;
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_busy(k)[3] !== 1'b0) begin
                n_bad++;
                $display("FAIL sb_clear dut%0d: busy3=%b want 0", k, act_busy(k)[3]);
            end
            n_cmp++;
        end
        // Busy r3 again, then write-clear it while reading it; also read r4 as it is set.
        idle(); bs = 1'b1; ba = 5'd3;
        tick();
        idle(); we = 1'b1; wa = 5'd3; wbe = 4'h0; bs = 1'b1; ba = 5'd4;
        re = 2'b11; ra = {5'd4, 5'd3};
        tick();
        if (act_rdb(0, 0) !== 1'b0 || act_rdb(1, 0) !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_bypass_clear: dut0=%b dut1=%b want 0/1", act_rdb(0, 0), act_rdb(1, 0));
        end
        n_cmp++;
        if (act_rdb(0, 1) !== 1'b0 || act_rdb(1, 1) !== 1'b0 || act_busy(0)[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_set_not_bypassed: rdb=%b/%b busy4=%b want 0/0/1",
                     act_rdb(0, 1), act_rdb(1, 1), act_busy(0)[4]);
        end
        n_cmp++;
    endtask

    task automatic test_out_of_range();
        idle(); we = 1'b1; wa = 5'd19; wd = 32'h00000011; wbe = 4'hF;
        tick();
        idle(); we = 1'b1; wa = 5'd25; wd = 32'hCAFEF00D; wbe = 4'hF; bs = 1'b1; ba = 5'd22;
        tick();
        idle(); re = 2'b11; ra = {5'd19, 5'd25};
        tick();
        if (act_rd(1, 0) !== 32'd0 || act_rdb(1, 0) !== 1'b0 || act_rd(1, 1) !== 32'h11) begin
            n_bad++;
            $display("FAIL oor_read dut1: rd=%h busy=%b rd19=%h want 0/0/11",
                     act_rd(1, 0), act_rdb(1, 0), act_rd(1, 1));
        end
        n_cmp++;
        if (act_rd(0, 0) !== 32'hCAFEF00D || act_busy(0)[22] !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_inrange dut0: rd=%h busy22=%b want cafef00d/1",
                     act_rd(0, 0), act_busy(0)[22]);
        end
        n_cmp++;
        if (act_busy(1) !== mbusy[1]) begin
            n_bad++;
            $display("FAIL oor_busy dut1: got %h want %h", act_busy(1), mbusy[1]);
        end
        n_cmp++;
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            re  = 2'($urandom);
            ra  = {rand_addr(), rand_addr()};
            we  = 1'($urandom);
            wa  = rand_addr();
            wd  = $urandom;
            wbe = 4'($urandom);
            bs  = ($urandom_range(0, 2) == 0);
            ba  = rand_addr();
            tick();
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 2; i++) begin
                    if (act_rd(k, i) !== mrd[k][i]) begin
                        n_bad++;
                        $display("FAIL rand_rd cyc%0d dut%0d port%0d: got %h want %h", n, k, i,
                                 act_rd(k, i), mrd[k][i]);
                    end
                    n_cmp++;
                    if (act_rdb(k, i) !== mrdb[k][i]) begin
                        n_bad++;
                        $display("FAIL rand_rdbusy cyc%0d dut%0d port%0d: got %b want %b", n, k,
                                 i, act_rdb(k, i), mrdb[k][i]);
                    end
                    n_cmp++;
                end
                if (act_busy(k) !== mbusy[k]) begin
                    n_bad++;
                    $display("FAIL rand_busy cyc%0d dut%0d: got %h want %h", n, k,
                             act_busy(k), mbusy[k]);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_async_reset();
        idle(); we = 1'b1; wa = 5'd9; wd = 32'h55; wbe = 4'hF;
        tick();
        idle(); bs = 1'b1; ba = 5'd9; re = 2'b01; ra = {5'd0, 5'd9};
        tick();
        if (act_rd(0, 0) !== 32'h55 || act_busy(0)[9] !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_r9: rd=%h busy9=%b want 55/1", act_rd(0, 0), act_busy(0)[9]);
        end
        n_cmp++;
        // Present a write and set that the reset must swallow.
        idle(); we = 1'b1; wa = 5'd9; wd = 32'h77; wbe = 4'hF; bs = 1'b1; ba = 5'd10;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (act_rd(k, 0) !== 32'd0 || act_rdb(k, 0) !== 1'b0 || act_busy(k) !== 32'd0) begin
                n_bad++;
                $display("FAIL async_clear dut%0d: rd=%h rdb=%b busy=%h want 0", k,
                         act_rd(k, 0), act_rdb(k, 0), act_busy(k));
            end
            n_cmp++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (act_busy(k) !== 32'd0 || act_rd(k, 0) !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_hold dut%0d: rd=%h busy=%h want 0", k,
                         act_rd(k, 0), act_busy(k));
            end
            n_cmp++;
        end
        #2 rst_n = 1'b1;
        model_reset();
        idle(); re = 2'b11; ra = {5'd10, 5'd9};
        tick();
        for (int k = 0; k < 2; k++) begin
            if (act_rd(k, 0) !== 32'd0 || act_rdb(k, 1) !== 1'b0 || act_busy(k) !== 32'd0) begin
                n_bad++;
                $display("FAIL post_reset_r9 dut%0d: rd=%h rdb10=%b busy=%h want 0", k,
                         act_rd(k, 0), act_rdb(k, 1), act_busy(k));
            end
            n_cmp++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_byte_write();
        test_same_edge();
        test_r0();
        test_scoreboard();
        test_out_of_range();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the data width in bits; XLEN SHALL be a multiple of 8.
REQ-002 The module SHALL have parameter NREG, default 32, giving the number of architectural registers; NREG SHALL be at least 2.
REQ-003 The module SHALL have parameter NRP, default 2, giving the number of read ports, range 1..4.
REQ-004 The module SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-005 The module SHALL derive AW = clog2(NREG) as an internal localparam.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port re, input, NRP bits: per-port read enable.
REQ-009 Port ra, input, NRP*AW bits: per-port read address; port i occupies bits [i*AW +: AW].
REQ-010 Port rd, output, NRP*XLEN bits: per-port registered read data.
REQ-011 Port rd_busy, output, NRP bits: per-port registered scoreboard status for the address sampled.
REQ-012 Port we, input, 1 bit: write enable.
REQ-013 Port wa, input, AW bits: write address.
REQ-014 Port wd, input, XLEN bits: write data.
REQ-015 Port wbe, input, XLEN/8 bits: write byte enables.
REQ-016 Port bs, input, 1 bit: scoreboard set request.
REQ-017 Port ba, input, AW bits: scoreboard set address.
REQ-018 Port busy, output, NREG bits: live scoreboard vector; bit 0 SHALL always read 0.

Function
REQ-019 Register 0 SHALL read as zero and SHALL ignore writes and scoreboard sets.
REQ-020 Any address >= NREG SHALL read as zero with rd_busy 0; writes and sets to it SHALL be ignored.
REQ-021 Write: on a rising edge with we=1 and a valid nonzero wa, each byte k with wbe[k]=1 SHALL take wd byte k; the other bytes SHALL be kept.
REQ-022 Read: on a rising edge with re[i]=1, rd port i SHALL load the value of register ra_i; latency is one cycle.
REQ-023 When re[i]=0, rd port i and rd_busy[i] SHALL hold their previous values.
REQ-024 Same-edge read/write, BYPASS=1: if ra_i equals a valid nonzero wa with we=1, rd port i SHALL return the byte-merged new value.
REQ-025 Same-edge read/write, BYPASS=0: in the same case, rd port i SHALL return the old value.
REQ-026 All NRP ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-027 Scoreboard set: bs=1 SHALL set busy[ba] on the edge.
REQ-028 Scoreboard clear: a write (we=1) to a valid nonzero wa SHALL clear busy[wa] on the edge, regardless of wbe.
REQ-029 If set and clear target the same address on the same edge, set SHALL win and the bit SHALL end at 1.
REQ-030 rd_busy[i] SHALL load busy[ra_i] as it stands before the edge.
REQ-031 With BYPASS=1, a same-edge write clear to ra_i SHALL be applied to rd_busy[i] (reads 0); a same-edge set SHALL NOT be applied.

Reset
REQ-032 While rst_n=0: all registers, rd, rd_busy and busy SHALL be 0 immediately, independent of clk.
REQ-033 Reset mid-operation SHALL discard any write or set presented on the same edge.
REQ-034 Normal operation SHALL resume on the first rising edge after rst_n returns to 1.

Structure
REQ-035 A shared package SHALL hold the default XLEN/NREG constants and a clog2 function used by the datapath blocks.
REQ-036 The module SHALL contain one sub-module, regfile_rport, instantiated NRP times; it holds the per-port address decode, bypass mux, hold register and busy lookup.
REQ-037 The module SHALL be preserved as a hierarchy boundary for synthesis.

Verification
REQ-038 Reset, then read r5 on port 0 -> rd0=0x00000000 and rd_busy0=0 one cycle later.
REQ-039 Write r5=0xDEADBEEF with wbe=1111, then write 0x000000AA with wbe=0001 -> a read of r5 returns 0xDEADBEAA.
REQ-040 Same-edge write r7=0x12345678 and read r7 on ports 0 and 1 -> 0x12345678 on both when BYPASS=1; the old value 0 on both when BYPASS=0.
REQ-041 Write r0=0xFFFFFFFF, then read r0 -> 0; set busy on r0 -> busy[0] stays 0.
REQ-042 bs on r3, then read r3 -> rd_busy=1; same-edge bs and we on r3 -> busy[3]=1; a lone write to r3 -> busy[3]=0.
REQ-043 Drop rst_n asynchronously after r9=0x55 -> rd and busy clear before the next clk edge; reading r9 after release returns 0.
